// File: rtl/stream_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stream block.
// Beat-length clamping lives here so loaders and testbenches agree on it.
package stream_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REWIND
    } ser_state_e;

    // Zero or out-of-range lengths select a full vector.
    function automatic int clamp_beats(input int n, input int beats);
        return (n == 0 || n > beats) ? beats : n;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Parallel-to-serial converter: loads a whole vector, emits OUT_LANES per beat.
// Rotate mode keeps the vector for replay, e.g. weights reused across neurons.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter  int INPUT_SIZE = 16,
    parameter  int Q_SIZE     = 16,
    parameter  int OUT_LANES  = 1,
    localparam int BEATS      = INPUT_SIZE / OUT_LANES,
    localparam int CNT_W      = $clog2(BEATS + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [INPUT_SIZE-1:0][Q_SIZE-1:0]   data_in,
    input  logic [CNT_W-1:0]                    in_beats,
    input  logic                                in_rotate,
    input  logic                                replay,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_LANES-1:0][Q_SIZE-1:0]    out_data,
    output logic                                out_last,
    output logic                                busy
);

    localparam int VEC_W = INPUT_SIZE * Q_SIZE;
    localparam int SH    = OUT_LANES * Q_SIZE;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    if (INPUT_SIZE % OUT_LANES != 0) begin : g_bad_lanes
        $error("INPUT_SIZE must be a multiple of OUT_LANES");
    end

    ser_state_e                         state;
    logic [INPUT_SIZE-1:0][Q_SIZE-1:0]  sreg;
    logic [INPUT_SIZE-1:0][Q_SIZE-1:0]  sreg_rot;
    logic                               held;
    logic                               rot_q;
    logic [CNT_W-1:0]                   len;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   rcnt;
    logic [CNT_W-1:0]                   len_in;
    logic                               xfer_last;
    logic                               load;

    // Rotate down by one beat: low lanes wrap to the top, nothing is lost.
    assign sreg_rot  = (sreg >> SH) | (sreg << (VEC_W - SH));
    assign len_in    = CNT_W'(clamp_beats(int'(in_beats), BEATS));
    assign xfer_last = (state == SHIFT) && out_ready && out_last;
    assign in_ready  = (state == IDLE) || (xfer_last && !rot_q);
    assign load      = in_valid && in_ready;
    assign out_data  = sreg[OUT_LANES-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            held      <= 1'b0;
            rot_q     <= 1'b0;
            len       <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            sreg      <= data_in;
            len       <= len_in;
            rot_q     <= in_rotate;
            cnt       <= '0;
            held      <= 1'b0;
            state     <= SHIFT;
            out_valid <= 1'b1;
            out_last  <= (len_in == ONE_C);
            busy      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (replay && held) begin
                        cnt       <= '0;
                        state     <= SHIFT;
                        out_valid <= 1'b1;
                        out_last  <= (len == ONE_C);
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        sreg <= sreg_rot;
                        if (!out_last) begin
                            cnt      <= cnt + ONE_C;
                            out_last <= (cnt + TWO_C == len);
                        end else begin
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (!rot_q) begin
                                state <= IDLE;
                                held  <= 1'b0;
                                busy  <= 1'b0;
                            end else if (len == BEATS_C) begin
                                state <= IDLE;
                                held  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= REWIND;
                                rcnt  <= BEATS_C - len;
                            end
                        end
                    end
                end
                REWIND: begin
                    // Finish the full circle so a replay starts at element 0.
                    sreg <= sreg_rot;
                    rcnt <= rcnt - ONE_C;
                    if (rcnt == ONE_C) begin
                        state <= IDLE;
                        held  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
